// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA timing source (800x600 @ 72 Hz from 50 MHz).
// Column/row counters plus registered sync, visible and start flags. Every flag
// is decoded from the next-state counter values and then registered, so flags and
// counters change on the same edge with no skew between them.
// Optional feature macro: VGA_TEST_PATTERN_EN adds pattern_rgb (eight vertical
// colour bars, registered and aligned with display_col).
module vga_timing_gen #(
   parameter int HOR_VISIBLE  = 800,
   parameter int HOR_FRONT    = 56,
   parameter int HOR_SYNC     = 120,
   parameter int HOR_BACK     = 64,
   parameter int VER_VISIBLE  = 600,
   parameter int VER_FRONT    = 37,
   parameter int VER_SYNC     = 6,
   parameter int VER_BACK     = 23,
   parameter int HSYNC_ACTIVE = 1,
   parameter int VSYNC_ACTIVE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pixel_en,
   output logic [11:0] display_col,
   output logic [10:0] display_row,
   output logic        hsync,
   output logic        vsync,
   output logic        visible,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [2:0]  pattern_rgb
`endif
);

   localparam int HOR_TOTAL = HOR_VISIBLE + HOR_FRONT + HOR_SYNC + HOR_BACK;
   localparam int VER_TOTAL = VER_VISIBLE + VER_FRONT + VER_SYNC + VER_BACK;

   // Counter widths are fixed by the port sizes; refuse to build otherwise.
   if (HOR_TOTAL > 4096) begin : g_hor_total_chk
      $error("vga_timing_gen: HOR_TOTAL exceeds 4096");
   end
   if (VER_TOTAL > 2048) begin : g_ver_total_chk
      $error("vga_timing_gen: VER_TOTAL exceeds 2048");
   end

   localparam logic [11:0] H_LAST = 12'(HOR_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(VER_TOTAL - 1);

   // Decode boundaries kept 32-bit so an end bound equal to 4096/2048 is exact.
   localparam int unsigned H_VIS_END  = HOR_VISIBLE;
   localparam int unsigned H_SYNC_BEG = HOR_VISIBLE + HOR_FRONT;
   localparam int unsigned H_SYNC_END = HOR_VISIBLE + HOR_FRONT + HOR_SYNC;
   localparam int unsigned V_VIS_END  = VER_VISIBLE;
   localparam int unsigned V_SYNC_BEG = VER_VISIBLE + VER_FRONT;
   localparam int unsigned V_SYNC_END = VER_VISIBLE + VER_FRONT + VER_SYNC;

   localparam logic HS_ON = (HSYNC_ACTIVE != 0);
   localparam logic VS_ON = (VSYNC_ACTIVE != 0);

   logic [11:0] col_q, col_d;
   logic [10:0] row_q, row_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        vis_q, vis_d;
   logic        ls_q, ls_d;
   logic        fs_q, fs_d;
   int unsigned c_n, r_n;

   // Next position: advance one column per enabled cycle, wrap line and frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (pixel_en) begin
         if (col_q == H_LAST) begin
            col_d = '0;
            row_d = (row_q == V_LAST) ? '0 : row_q + 11'd1;
         end else begin
            col_d = col_q + 12'd1;
         end
      end
   end

   // Flag decode of the next position; registering these keeps them aligned.
   always_comb begin
      c_n     = 32'(col_d);
      r_n     = 32'(row_d);
      hsync_d = (c_n >= H_SYNC_BEG && c_n < H_SYNC_END) ? HS_ON : ~HS_ON;
      vsync_d = (r_n >= V_SYNC_BEG && r_n < V_SYNC_END) ? VS_ON : ~VS_ON;
      vis_d   = (c_n < H_VIS_END) && (r_n < V_VIS_END);
      ls_d    = (col_d == '0);
      fs_d    = (col_d == '0) && (row_d == '0);
   end

   // Position and flag registers; reset lands on the decode of (0,0).
   always_ff @(posedge clock) begin
      if (!reset) begin
         col_q   <= '0;
         row_q   <= '0;
         hsync_q <= ~HS_ON;
         vsync_q <= ~VS_ON;
         vis_q   <= 1'b1;
         ls_q    <= 1'b1;
         fs_q    <= 1'b1;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         vis_q   <= vis_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign display_col = col_q;
   assign display_row = row_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign visible     = vis_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
   localparam int unsigned BAR_W = HOR_VISIBLE / 8;

   logic [2:0] pat_q, pat_d;
   logic [2:0] bar;

   // Bar index by threshold count (avoids a divider); bars run white to black.
   always_comb begin
      bar = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (c_n >= i * BAR_W) bar = bar + 3'd1;
      end
      pat_d = vis_d ? (3'd7 - bar) : 3'd0;
   end

   // Pattern register, aligned with the counters.
   always_ff @(posedge clock) begin
      if (!reset) pat_q <= 3'b111;
      else        pat_q <= pat_d;
   end

   assign pattern_rgb = pat_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A uses the default 800x600 timing for line
// and enable-gating checks; instance B uses a scaled-down timing so whole frames,
// vsync windows and a mid-frame reset fit in a short run. Both are also driven
// with random enable/reset traffic against a linear-position model.
module tb_vga_timing_gen;

   logic        clock = 1'b0;
   logic        reset_a, en_a, reset_b, en_b;
   logic [11:0] col_a, col_b;
   logic [10:0] row_a, row_b;
   logic        hs_a, vs_a, vis_a, ls_a, fs_a;
   logic        hs_b, vs_b, vis_b, ls_b, fs_b;
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0]  pat_a, pat_b;
`endif

   int checks = 0;
   int failures = 0;

   // Scaled timing for instance B: 30 x 21 = 630 clocks per frame.
   localparam int BHV = 16, BHF = 4, BHS = 6, BHB = 4;
   localparam int BVV = 12, BVF = 3, BVS = 2, BVB = 4;

   always #5 clock = ~clock;

   vga_timing_gen dut_a (
      .clock(clock), .reset(reset_a), .pixel_en(en_a),
      .display_col(col_a), .display_row(row_a),
      .hsync(hs_a), .vsync(vs_a), .visible(vis_a),
      .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TEST_PATTERN_EN
      , .pattern_rgb(pat_a)
`endif
   );

   vga_timing_gen #(
      .HOR_VISIBLE(BHV), .HOR_FRONT(BHF), .HOR_SYNC(BHS), .HOR_BACK(BHB),
      .VER_VISIBLE(BVV), .VER_FRONT(BVF), .VER_SYNC(BVS), .VER_BACK(BVB),
      .HSYNC_ACTIVE(1), .VSYNC_ACTIVE(1)
   ) dut_b (
      .clock(clock), .reset(reset_b), .pixel_en(en_b),
      .display_col(col_b), .display_row(row_b),
      .hsync(hs_b), .vsync(vs_b), .visible(vis_b),
      .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TEST_PATTERN_EN
      , .pattern_rgb(pat_b)
`endif
   );

   typedef struct {
      int col, row, hs, vs, vis, ls, fs, pat;
   } exp_t;

   typedef struct {
      bit rst;
      bit en;
      int n;
      int col, row;
      int hs, vs, vis, ls, fs;
   } vec_t;

   // Linear position t = row*H + col; all outputs follow from range rules.
   function automatic exp_t model(input int t, input int hv, hf, hs, hb,
                                  input int vv, vf, vs, vb);
      exp_t e;
      int h;
      h      = hv + hf + hs + hb;
      e.col  = t % h;
      e.row  = t / h;
      e.hs   = (e.col >= hv + hf && e.col < hv + hf + hs) ? 1 : 0;
      e.vs   = (e.row >= vv + vf && e.row < vv + vf + vs) ? 1 : 0;
      e.vis  = (e.col < hv && e.row < vv) ? 1 : 0;
      e.ls   = (e.col == 0) ? 1 : 0;
      e.fs   = (e.col == 0 && e.row == 0) ? 1 : 0;
      e.pat  = e.vis ? 7 - e.col / (hv / 8) : 0;
      return e;
   endfunction

   int t_a = 0, t_b = 0;
   localparam int TOT_A = 1040 * 666;
   localparam int TOT_B = (BHV + BHF + BHS + BHB) * (BVV + BVF + BVS + BVB);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock on A (B frozen), model updated on the edge, sampled at negedge.
   task automatic step_a(input bit rst, input bit en);
      reset_a = rst; en_a = en; reset_b = 1'b1; en_b = 1'b0;
      @(posedge clock);
      if (!rst) t_a = 0; else if (en) t_a = (t_a + 1) % TOT_A;
      @(negedge clock);
   endtask

   task automatic step_b(input bit rst, input bit en);
      reset_b = rst; en_b = en; reset_a = 1'b1; en_a = 1'b0;
      @(posedge clock);
      if (!rst) t_b = 0; else if (en) t_b = (t_b + 1) % TOT_B;
      @(negedge clock);
   endtask

   task automatic cmp_a(input string tag);
      exp_t e;
      e = model(t_a, 800, 56, 120, 64, 600, 37, 6, 23);
      chk({tag, "_col"}, 32'(col_a), e.col);
      chk({tag, "_row"}, 32'(row_a), e.row);
      chk({tag, "_hs"},  32'(hs_a),  e.hs);
      chk({tag, "_vs"},  32'(vs_a),  e.vs);
      chk({tag, "_vis"}, 32'(vis_a), e.vis);
      chk({tag, "_ls"},  32'(ls_a),  e.ls);
      chk({tag, "_fs"},  32'(fs_a),  e.fs);
`ifdef VGA_TEST_PATTERN_EN
      chk({tag, "_pat"}, 32'(pat_a), e.pat);
`endif
   endtask

   task automatic cmp_b(input string tag);
      exp_t e;
      e = model(t_b, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
      chk({tag, "_col"}, 32'(col_b), e.col);
      chk({tag, "_row"}, 32'(row_b), e.row);
      chk({tag, "_hs"},  32'(hs_b),  e.hs);
      chk({tag, "_vs"},  32'(vs_b),  e.vs);
      chk({tag, "_vis"}, 32'(vis_b), e.vis);
      chk({tag, "_ls"},  32'(ls_b),  e.ls);
      chk({tag, "_fs"},  32'(fs_b),  e.fs);
`ifdef VGA_TEST_PATTERN_EN
      chk({tag, "_pat"}, 32'(pat_b), e.pat);
`endif
   endtask

   vec_t tbl[14];
   int   vs_cnt;

   initial begin
      // {rst, en, cycles, col, row, hs, vs, vis, ls, fs} on the default timing.
      tbl[0]  = '{1'b0, 1'b1,    3,    0, 0, 0, 0, 1, 1, 1};  // reset held 3 clocks
      tbl[1]  = '{1'b1, 1'b1,  799,  799, 0, 0, 0, 1, 0, 0};  // last visible column
      tbl[2]  = '{1'b1, 1'b1,    1,  800, 0, 0, 0, 0, 0, 0};  // visible falls
      tbl[3]  = '{1'b1, 1'b1,   55,  855, 0, 0, 0, 0, 0, 0};  // just before hsync
      tbl[4]  = '{1'b1, 1'b1,    1,  856, 0, 1, 0, 0, 0, 0};  // hsync rises
      tbl[5]  = '{1'b1, 1'b1,  119,  975, 0, 1, 0, 0, 0, 0};  // last hsync column
      tbl[6]  = '{1'b1, 1'b1,    1,  976, 0, 0, 0, 0, 0, 0};  // hsync falls
      tbl[7]  = '{1'b1, 1'b1,   63, 1039, 0, 0, 0, 0, 0, 0};  // end of line
      tbl[8]  = '{1'b1, 1'b1,    1,    0, 1, 0, 0, 1, 1, 0};  // line wrap
      tbl[9]  = '{1'b1, 1'b1, 1038, 1038, 1, 0, 0, 0, 0, 0};
      tbl[10] = '{1'b1, 1'b1,    1, 1039, 1, 0, 0, 0, 0, 0};  // enable 1
      tbl[11] = '{1'b1, 1'b0,    1, 1039, 1, 0, 0, 0, 0, 0};  // enable 0: frozen
      tbl[12] = '{1'b1, 1'b0,    1, 1039, 1, 0, 0, 0, 0, 0};  // enable 0: frozen
      tbl[13] = '{1'b1, 1'b1,    1,    0, 2, 0, 0, 1, 1, 0};  // enable 1: wrap

      reset_a = 1'b0; en_a = 1'b0; reset_b = 1'b0; en_b = 1'b0;
      @(negedge clock);
      @(negedge clock);

      // Instance A: table vectors for reset, line timing and enable gating.
      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < tbl[i].n; k++) step_a(tbl[i].rst, tbl[i].en);
         chk($sformatf("vec%0d_col", i), 32'(col_a), tbl[i].col);
         chk($sformatf("vec%0d_row", i), 32'(row_a), tbl[i].row);
         chk($sformatf("vec%0d_hs", i),  32'(hs_a),  tbl[i].hs);
         chk($sformatf("vec%0d_vs", i),  32'(vs_a),  tbl[i].vs);
         chk($sformatf("vec%0d_vis", i), 32'(vis_a), tbl[i].vis);
         chk($sformatf("vec%0d_ls", i),  32'(ls_a),  tbl[i].ls);
         chk($sformatf("vec%0d_fs", i),  32'(fs_a),  tbl[i].fs);
      end
`ifdef VGA_TEST_PATTERN_EN
      chk("a_pat_wrap", 32'(pat_a), 7);
`endif

      // Instance A: random enable with rare resets against the model.
      t_a = 2 * 1040;
      for (int i = 0; i < 3000; i++) begin
         step_a($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0);
         cmp_a("a_rnd");
      end

      // Instance B: one full frame with enable high; count vsync cycles.
      step_b(1'b0, 1'b1);
      cmp_b("b_rst");
      vs_cnt = 0;
      for (int i = 0; i < TOT_B; i++) begin
         step_b(1'b1, 1'b1);
         cmp_b("b_frame");
         if (vs_b === 1'b1) vs_cnt++;
      end
      chk("b_vs_cycles", vs_cnt, BVS * (BHV + BHF + BHS + BHB));
      chk("b_frame_fs",  32'(fs_b),  1);
      chk("b_frame_col", 32'(col_b), 0);
      chk("b_frame_row", 32'(row_b), 0);

      // Instance B: mid-frame reset while both syncs are active (col 22, row 15).
      step_b(1'b0, 1'b1);
      for (int i = 0; i < 15 * 30 + 22; i++) step_b(1'b1, 1'b1);
      chk("b_mid_col", 32'(col_b), 22);
      chk("b_mid_row", 32'(row_b), 15);
      chk("b_mid_hs",  32'(hs_b),  1);
      chk("b_mid_vs",  32'(vs_b),  1);
      step_b(1'b0, 1'b1);
      chk("b_mrst_col", 32'(col_b), 0);
      chk("b_mrst_row", 32'(row_b), 0);
      chk("b_mrst_hs",  32'(hs_b),  0);
      chk("b_mrst_vs",  32'(vs_b),  0);
      chk("b_mrst_fs",  32'(fs_b),  1);

      // Instance B: random traffic spanning several frames.
      for (int i = 0; i < 3000; i++) begin
         step_b($urandom_range(0, 799) != 0, $urandom_range(0, 7) != 0);
         cmp_b("b_rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Transmit-side VGA timing source. It free-runs horizontal and vertical counters and drives hsync, vsync, visible and pixel coordinates for an 800x600 @ 72 Hz display from the 50 MHz system clock. Its sync outputs drive the monitor connector and feed the existing sync-tracking controller, which recovers column and row from them. All outputs are registered and mutually aligned.

Parameters:
HOR_VISIBLE, 800, active pixels per line
HOR_FRONT, 56, horizontal front porch in clocks
HOR_SYNC, 120, hsync pulse width in clocks
HOR_BACK, 64, horizontal back porch in clocks; HOR_TOTAL = sum of the four = 1040
VER_VISIBLE, 600, active lines per frame
VER_FRONT, 37, vertical front porch in lines
VER_SYNC, 6, vsync pulse width in lines
VER_BACK, 23, vertical back porch in lines; VER_TOTAL = sum of the four = 666
HSYNC_ACTIVE, 1, active level of hsync
VSYNC_ACTIVE, 1, active level of vsync

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
pixel_en  input  1  count enable; counters advance only on cycles where it is 1
display_col  output  12  current column, 0..HOR_TOTAL-1
display_row  output  11  current row, 0..VER_TOTAL-1
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
visible  output  1  high when col < HOR_VISIBLE and row < VER_VISIBLE
line_start  output  1  high while display_col == 0
frame_start  output  1  high while display_col == 0 and display_row == 0

Behaviour:
- Reset is sampled on the rising clock edge while reset == 0. It has priority over pixel_en.
- Reset values: display_col = 0, display_row = 0, hsync = !HSYNC_ACTIVE, vsync = !VSYNC_ACTIVE, visible = 1, line_start = 1, frame_start = 1. These equal the decode of position (0,0).
- Reset asserted mid-frame returns to (0,0) on the next edge. No partial sync pulse is extended.
- Alignment: in every cycle, hsync, vsync, visible, line_start and frame_start are the decode of the display_col and display_row values present in that same cycle.
- Implementation: decode flags from the next-state counter values and register them, giving zero skew between counters and flags.
- pixel_en == 0: every output holds its value. pixel_en == 1: col advances by 1.
- Line wrap: col == HOR_TOTAL-1 wraps to 0 and row increments.
- Frame wrap: row == VER_TOTAL-1 together with a line wrap sends row to 0.
- hsync is active for col in [HOR_VISIBLE+HOR_FRONT, HOR_VISIBLE+HOR_FRONT+HOR_SYNC), i.e. 856..975 by default. It is inactive elsewhere.
- vsync is active for row in [VER_VISIBLE+VER_FRONT, VER_VISIBLE+VER_FRONT+VER_SYNC), i.e. 637..642 by default, across all columns of those rows.
- Frame period with pixel_en tied high: HOR_TOTAL*VER_TOTAL = 692640 clocks. The line period is 1040 clocks.
- Arithmetic: counters are unsigned and compared against parameter-derived constants.
- HOR_TOTAL must be <= 4096 and VER_TOTAL must be <= 2048. An elaboration-time check fails the build otherwise.
- Counters never leave their legal ranges, so no out-of-range recovery logic is needed.

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
- Defined: adds output port pattern_rgb (3 bits, registered, aligned with display_col) carrying eight vertical colour bars.
  - Bar index = display_col / (HOR_VISIBLE/8), so 100 columns per bar by default.
  - pattern_rgb = 7 - bar index while visible; 3'b000 while not visible.
  - Reset value 3'b111.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 clocks with pixel_en=1 -> col=0, row=0, hsync=0, vsync=0, visible=1, frame_start=1.
- Line timing: release reset, pixel_en=1 -> hsync rises when col reaches 856, falls when col reaches 976; visible falls at col 800. After col 1039, col=0, row=1, line_start=1.
- Frame timing: run 692640 clocks -> vsync high exactly for rows 637..642 (6*1040 = 6240 clocks); frame_start high again at clock 692640 with col=0, row=0.
- Enable gating: toggle pixel_en with pattern 1,0,0,1 across col 1039 -> outputs frozen during the 0 cycles; wrap to (0, row+1) occurs only on an enabled edge.
- Mid-frame reset: assert reset at col=900, row=640 (hsync and vsync both active) -> next edge col=0, row=0, hsync=0, vsync=0.
- VGA_TEST_PATTERN_EN defined: row 10 -> pattern_rgb=7 at col 0..99, 6 at col 100..199, 0 at col 700..799, 0 at col 800..1039.
